// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock-divider controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    // Smallest ratio that still yields a real high and low phase.
    localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter for the divider: counts 0..ratio-1 while running, flags the
// last cycle of the period and produces the registered divided clock and the
// period-start tick. Outputs are computed from the next count so they line up
// with the count they describe.
module clk_div_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] ratio,
    output logic             boundary,
    output logic             clk_div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] high_len;
    logic             run_q;

    // Last cycle of the period; never asserted while stopped.
    assign boundary = run_q && (cnt == (ratio - ONE));

    // ceil(ratio/2) written without ratio+1 so the largest ratio cannot wrap.
    assign high_len = (ratio >> 1) + {{(DIV_W-1){1'b0}}, ratio[0]};

    // A period restarts at 0 when leaving OFF, after the boundary, or when stopped.
    assign cnt_nxt = (!run || !run_q || boundary) ? '0 : (cnt + ONE);

    // Count register plus registered duty compare and tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            run_q   <= 1'b0;
            clk_div <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            run_q   <= run;
            clk_div <= run && (cnt_nxt < high_len);
            tick    <= run && (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time programmable integer clock divider. Ratio updates arrive over a
// valid/ready handshake and only take effect at a period boundary, so the
// divided clock never glitches. enable starts and stops the divider cleanly.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_div,
    output logic             tick,
    output logic             running,
    output logic [DIV_W-1:0] cur_div
);

    localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DIV_RESET);

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] cur_nxt;
    logic [DIV_W-1:0] pend_nxt;
    logic             boundary;
    logic             accept;
    logic             cfg_ok;
    logic             run;

    assign accept = cfg_valid && cfg_ready;
    assign cfg_ok = (cfg_div >= MIN_DIV);
    assign run    = (state_nxt != OFF);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and ratio bookkeeping; boundary actions take precedence.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_div;
        pend_nxt  = pend_div;
        case (state)
            OFF: begin
                if (accept && cfg_ok) cur_nxt = cfg_div;
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                if (boundary) begin
                    if (accept && cfg_ok) cur_nxt = cfg_div;
                    if (!enable) state_nxt = OFF;
                end else if (accept && cfg_ok) begin
                    pend_nxt  = cfg_div;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (boundary) begin
                    cur_nxt   = pend_div;
                    state_nxt = enable ? RUN : OFF;
                end
            end
            default: state_nxt = OFF;
        endcase
    end

    // Registered ratios and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_div   <= RESET_DIV;
            pend_div  <= RESET_DIV;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
            running   <= 1'b0;
        end else begin
            cur_div   <= cur_nxt;
            pend_div  <= pend_nxt;
            cfg_ready <= (state_nxt != PEND);
            cfg_err   <= accept && !cfg_ok;
            running   <= run;
        end
    end

    clk_div_cnt #(
        .DIV_W(DIV_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .ratio    (cur_div),
        .boundary (boundary),
        .clk_div  (clk_div),
        .tick     (tick)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random traffic, all checked
// against a behavioural model of the divided waveform.
module tb_clk_div_ctrl;

    localparam int DIV_W     = 8;
    localparam int DIV_RESET = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_div;
    logic             tick;
    logic             running;
    logic [DIV_W-1:0] cur_div;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: is a period being generated, position in it, its length,
    // a queued ratio (0 = none) and the registered error flag.
    bit m_active;
    int m_pos;
    int m_n;
    int m_pend;
    bit m_err;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .DIV_W     (DIV_W),
        .DIV_RESET (DIV_RESET)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_div   (clk_div),
        .tick      (tick),
        .running   (running),
        .cur_div   (cur_div)
    );

    function automatic logic [12:0] observed();
        return {clk_div, tick, running, cfg_ready, cfg_err, cur_div};
    endfunction

    function automatic logic [12:0] expected();
        logic e_clk;
        logic e_tick;
        e_clk  = m_active && (m_pos < (m_n + 1) / 2);
        e_tick = m_active && (m_pos == 0);
        return {e_clk, e_tick, m_active, (m_pend == 0), m_err, 8'(m_n)};
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_pos    = 0;
        m_n      = DIV_RESET;
        m_pend   = 0;
        m_err    = 0;
    endtask

    task automatic model_step();
        bit accept;
        bit good;
        accept = cfg_valid && (m_pend == 0);
        good   = accept && (int'(cfg_div) >= 2);
        m_err  = accept && (int'(cfg_div) < 2);
        if (!m_active) begin
            if (good) m_n = int'(cfg_div);
            if (enable) begin
                m_active = 1;
                m_pos    = 0;
            end
        end else if (m_pos == m_n - 1) begin
            if (m_pend != 0) m_n = m_pend;
            m_pend = 0;
            if (good) m_n = int'(cfg_div);
            m_pos = 0;
            if (!enable) m_active = 0;
        end else begin
            m_pos++;
            if (good) m_pend = int'(cfg_div);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    // Steps without checking until the model sits at the wanted position
    // with the wanted ratio and nothing queued.
    task automatic advance_to(input int pos, input int n);
        int guard;
        guard = 0;
        while (!(m_active && m_pos == pos && m_n == n && m_pend == 0) && guard < 1000) begin
            step();
            guard++;
        end
        if (guard >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL advance_to: timeout waiting pos %0d n %0d (at pos %0d n %0d)", pos, n, m_pos, m_n);
        end
    endtask

    task automatic offer(input int div);
        cfg_valid = 1'b1;
        cfg_div   = 8'(div);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (observed() !== 13'b0_0_0_1_0_00000011) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", observed(), 13'b0_0_0_1_0_00000011);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_n3();
        int ticks;
        ticks  = 0;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (tick) ticks++;
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL basic_n3 cyc %0d: got %h want %h", i, observed(), expected());
            end
            if (i == 0) begin
                n_checks++;
                if (tick !== 1'b1 || clk_div !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_first_tick: got tick %b clk %b want 1 1", tick, clk_div);
                end
            end
        end
        n_checks++;
        if (ticks != 4) begin
            n_fail++;
            $display("FAIL basic_tick_count: got %0d want 4", ticks);
        end
    endtask

    task automatic test_reconfig_mid();
        offer(4);
        advance_to(1, 4);
        offer(6);
        n_checks++;
        if (cfg_ready !== 1'b0 || cur_div !== 8'd4) begin
            n_fail++;
            $display("FAIL mid_pend: got ready %b cur %0d want 0 4", cfg_ready, cur_div);
        end
        for (int i = 0; i < 14; i++) begin
            step();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL reconfig_mid cyc %0d: got %h want %h", i, observed(), expected());
            end
        end
        n_checks++;
        if (cur_div !== 8'd6 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_applied: got cur %0d ready %b want 6 1", cur_div, cfg_ready);
        end
    endtask

    task automatic test_boundary_cfg();
        offer(3);
        advance_to(2, 3);
        offer(5);
        n_checks++;
        if (cfg_ready !== 1'b1 || cur_div !== 8'd5 || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_cfg: got ready %b cur %0d tick %b want 1 5 1", cfg_ready, cur_div, tick);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL boundary_cfg cyc %0d: got %h want %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_invalid();
        offer(1);
        n_checks++;
        if (cfg_err !== 1'b1 || cur_div !== 8'd5 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_1: got err %b cur %0d ready %b want 1 5 1", cfg_err, cur_div, cfg_ready);
        end
        offer(0);
        n_checks++;
        if (cfg_err !== 1'b1 || cur_div !== 8'd5) begin
            n_fail++;
            $display("FAIL invalid_0: got err %b cur %0d want 1 5", cfg_err, cur_div);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL invalid cyc %0d: got %h want %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_stop();
        int more;
        offer(8);
        advance_to(1, 8);
        enable = 1'b0;
        more   = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL stop cyc %0d: got %h want %h", i, observed(), expected());
            end
            if (!running) break;
            more++;
        end
        n_checks++;
        if (more != 6 || clk_div !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_len: got %0d cycles clk %b run %b want 6 0 0", more, clk_div, running);
        end
        enable = 1'b1;
        step();
        n_checks++;
        if (tick !== 1'b1 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_tick: got tick %b run %b want 1 1", tick, running);
        end
        advance_to(2, 8);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) step();
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (running !== 1'b1 || observed() !== expected()) begin
                n_fail++;
                $display("FAIL cancel_stop cyc %0d: got %h want %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_reset_pend();
        advance_to(1, 8);
        offer(7);
        step();
        n_checks++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_entry: got ready %b want 0", cfg_ready);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (observed() !== 13'b0_0_0_1_0_00000011) begin
            n_fail++;
            $display("FAIL reset_mid_pend: got %h want %h", observed(), 13'b0_0_0_1_0_00000011);
        end
        model_reset();
        #3;
        rst = 1'b0;
        step();
        n_checks++;
        if (observed() !== expected() || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset: got %h want %h", observed(), expected());
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 600; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            r         = int'($urandom_range(0, 15));
            if (r == 15) cfg_div = 8'd255;
            else if (r == 14) cfg_div = 8'd254;
            else cfg_div = 8'(r % 8);
            step();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", i, observed(), expected());
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_n3();
        test_reconfig_mid();
        test_boundary_cfg();
        test_invalid();
        test_stop();
        test_reset_pend();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
